// File: rtl/cnt_pkg.sv
// Shared definitions for the modulo-N up/down counter: direction encoding and load clamp.
// Pure combinational helpers; no state and no backpressure.
package cnt_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Out-of-range load values saturate to the top of the count range.
  function automatic logic [15:0] clamp_load(input logic [15:0] val, input logic [16:0] modulus);
    logic [16:0] lim;
    lim = modulus - 17'd1;
    if ({1'b0, val} > lim) return lim[15:0];
    return val;
  endfunction

endpackage

// File: rtl/d_ff_ar.sv
// Single-bit D flip-flop with asynchronous active-high reset and complementary output.
// Latency 1 cycle from d to q; no backpressure.
module d_ff_ar (
  output logic q,
  output logic qbar,
  input  logic clk,
  input  logic d,
  input  logic rst
);

  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= d;
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous modulo-N up/down counter with load, terminal count, wrap pulse and sticky overflow.
// Latency 1 cycle from en/load to count; no backpressure, tc is combinational for cascading.
module sync_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_count_n;
  logic [WIDTH-1:0] w_count_d;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_wrap_d;
  logic             w_wrap_q;
  logic             w_wrap_n;
  logic             w_ovf_d;
  logic             w_ovf_q;
  logic             w_ovf_n;

  assign w_at_max  = (w_count == LP_MAX);
  assign w_at_zero = (w_count == '0);
  assign w_inc     = w_count + WIDTH'(1);
  // count-1 taken from the inverted rail: ~(~count + 1) == count - 1.
  assign w_dec     = ~(w_count_n + WIDTH'(1));

  assign w_load_clamped = WIDTH'(clamp_load(16'(load_val), 17'(MODULUS)));

  assign tc = en & (((up_dn == DIR_UP) & w_at_max) | ((up_dn == DIR_DN) & w_at_zero));

  always_comb begin
    w_count_d = w_count;
    w_wrap_d  = 1'b0;
    if (load) begin
      w_count_d = w_load_clamped;
    end else if (en) begin
      w_wrap_d = tc;
      if (up_dn == DIR_UP) w_count_d = w_at_max  ? '0     : w_inc;
      else                 w_count_d = w_at_zero ? LP_MAX : w_dec;
    end
  end

  // A wrap on this edge overrides a simultaneous clear.
  assign w_ovf_d = w_wrap_d | (~clr_ovf & ~w_ovf_n);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_count
    d_ff_ar u_bit (
      .q    (w_count[gi]),
      .qbar (w_count_n[gi]),
      .clk  (clk),
      .d    (w_count_d[gi]),
      .rst  (rst)
    );
  end

  d_ff_ar u_wrap (
    .q    (w_wrap_q),
    .qbar (w_wrap_n),
    .clk  (clk),
    .d    (w_wrap_d),
    .rst  (rst)
  );

  d_ff_ar u_ovf (
    .q    (w_ovf_q),
    .qbar (w_ovf_n),
    .clk  (clk),
    .d    (w_ovf_d),
    .rst  (rst)
  );

  assign count = w_count;
  // Both rails of the wrap cell agree; combining them keeps the pulse clean.
  assign wrap  = w_wrap_q & ~w_wrap_n;
  assign ovf   = w_ovf_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: MODULUS=10 and MODULUS=2 instances against an arithmetic model.
module tb_sync_updown_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       en_a = 1'b0, up_a = 1'b0, ld_a = 1'b0, clr_a = 1'b0;
  logic [3:0] lv_a = 4'd0;
  logic [3:0] cnt_a;
  logic       tc_a, wr_a, ov_a;

  logic       en_b = 1'b0, up_b = 1'b0, ld_b = 1'b0, clr_b = 1'b0;
  logic [0:0] lv_b = 1'b0;
  logic [0:0] cnt_b;
  logic       tc_b, wr_b, ov_b;

  int checks   = 0;
  int failures = 0;

  int ma_cnt = 0, mb_cnt = 0;
  bit ma_wr = 0, ma_ov = 0, mb_wr = 0, mb_ov = 0;

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .up_dn(up_a), .load(ld_a), .load_val(lv_a),
    .clr_ovf(clr_a), .count(cnt_a), .tc(tc_a), .wrap(wr_a), .ovf(ov_a)
  );

  sync_updown_counter #(.WIDTH(1), .MODULUS(2)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .up_dn(up_b), .load(ld_b), .load_val(lv_b),
    .clr_ovf(clr_b), .count(cnt_b), .tc(tc_b), .wrap(wr_b), .ovf(ov_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // tc means: a step taken now would leave the range 0..modv-1.
  function automatic int model_tc(input int modv, input bit e, input bit u, input int cnt);
    int nxt;
    nxt = u ? cnt + 1 : cnt - 1;
    return (e && (nxt < 0 || nxt >= modv)) ? 1 : 0;
  endfunction

  function automatic void step_model(input int modv, input bit e, input bit u, input bit l,
                                     input bit c, input int lval,
                                     inout int cnt, inout bit w, inout bit o);
    int nxt;
    w = 1'b0;
    if (l) begin
      cnt = (lval >= modv) ? modv - 1 : lval;
      if (c) o = 1'b0;
    end else if (e) begin
      nxt = u ? cnt + 1 : cnt - 1;
      w   = (nxt < 0) || (nxt >= modv);
      cnt = (nxt + modv) % modv;
      if (w) o = 1'b1;
      else if (c) o = 1'b0;
    end else if (c) begin
      o = 1'b0;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_cnt = 0; ma_wr = 0; ma_ov = 0;
      mb_cnt = 0; mb_wr = 0; mb_ov = 0;
    end else begin
      step_model(10, en_a, up_a, ld_a, clr_a, int'(lv_a), ma_cnt, ma_wr, ma_ov);
      step_model(2,  en_b, up_b, ld_b, clr_b, int'(lv_b), mb_cnt, mb_wr, mb_ov);
    end
  end

  always @(negedge clk) begin
    check("a_count", 32'(cnt_a), ma_cnt);
    check("a_tc",    32'(tc_a),  model_tc(10, en_a, up_a, ma_cnt));
    check("a_wrap",  32'(wr_a),  int'(ma_wr));
    check("a_ovf",   32'(ov_a),  int'(ma_ov));
    check("b_count", 32'(cnt_b), mb_cnt);
    check("b_tc",    32'(tc_b),  model_tc(2, en_b, up_b, mb_cnt));
    check("b_wrap",  32'(wr_b),  int'(mb_wr));
    check("b_ovf",   32'(ov_b),  int'(mb_ov));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(2);
    check("pin_rst_count", 32'(cnt_a), 0);
    check("pin_rst_wrap",  32'(wr_a),  0);
    check("pin_rst_ovf",   32'(ov_a),  0);
    en_a = 1'b1; up_a = 1'b0;
    #1 check("pin_rst_tc_down", 32'(tc_a), 1);

    // Up count through a wrap
    rst = 1'b0; up_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("pin_up_count", 32'(cnt_a), i);
      check("pin_up_tc",    32'(tc_a),  (i == 9) ? 1 : 0);
      tick();
    end
    check("pin_up_wrapped_count", 32'(cnt_a), 0);
    check("pin_up_wrap",          32'(wr_a),  1);
    check("pin_up_ovf",           32'(ov_a),  1);
    en_a = 1'b0;
    tick();
    check("pin_up_wrap_gone", 32'(wr_a), 0);
    check("pin_up_ovf_held",  32'(ov_a), 1);

    // Asynchronous reset mid-count
    en_a = 1'b1;
    tick(7);
    check("pin_mid_count", 32'(cnt_a), 7);
    #2 rst = 1'b1;
    #1;
    check("pin_async_count", 32'(cnt_a), 0);
    check("pin_async_wrap",  32'(wr_a),  0);
    check("pin_async_ovf",   32'(ov_a),  0);
    tick();
    check("pin_rst_held_count", 32'(cnt_a), 0);
    rst = 1'b0; en_a = 1'b0;
    tick();

    // Down count through a wrap, then clear ovf
    en_a = 1'b1; up_a = 1'b0;
    #1 check("pin_down_tc", 32'(tc_a), 1);
    tick();
    check("pin_down_count", 32'(cnt_a), 9);
    check("pin_down_wrap",  32'(wr_a),  1);
    check("pin_down_ovf",   32'(ov_a),  1);
    en_a = 1'b0; clr_a = 1'b1;
    tick();
    check("pin_clr_ovf",  32'(ov_a), 0);
    check("pin_clr_wrap", 32'(wr_a), 0);
    clr_a = 1'b0;

    // Load beats a wrapping step
    en_a = 1'b1; up_a = 1'b1; ld_a = 1'b1; lv_a = 4'd5;
    #1 check("pin_load_tc", 32'(tc_a), 1);
    tick();
    check("pin_load_count", 32'(cnt_a), 5);
    check("pin_load_wrap",  32'(wr_a),  0);
    check("pin_load_ovf",   32'(ov_a),  0);
    en_a = 1'b0; lv_a = 4'd12;
    tick();
    check("pin_load_clamp", 32'(cnt_a), 9);

    // Hold, then direction toggling
    lv_a = 4'd4;
    tick();
    ld_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pin_hold_count", 32'(cnt_a), 4);
      check("pin_hold_tc",    32'(tc_a),  0);
    end
    en_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_a = (i % 2 == 0);
      tick();
      check("pin_toggle_count", 32'(cnt_a), (i % 2 == 0) ? 5 : 4);
    end
    en_a = 1'b0;

    // Set beats clear on the wrapping edge
    ld_a = 1'b1; lv_a = 4'd9;
    tick();
    ld_a = 1'b0; en_a = 1'b1; up_a = 1'b1; clr_a = 1'b1;
    tick();
    check("pin_collide_count", 32'(cnt_a), 0);
    check("pin_collide_wrap",  32'(wr_a),  1);
    check("pin_collide_ovf",   32'(ov_a),  1);
    en_a = 1'b0; clr_a = 1'b0;
    tick();
    check("pin_collide_wrap_gone", 32'(wr_a), 0);

    // MODULUS=2: every step wraps when direction alternates
    en_b = 1'b1; up_b = 1'b1;
    tick();
    check("pin_m2_first_count", 32'(cnt_b), 1);
    check("pin_m2_first_wrap",  32'(wr_b),  0);
    #1 check("pin_m2_tc", 32'(tc_b), 1);
    for (int k = 0; k < 4; k++) begin
      up_b = (k % 2 == 0);
      tick();
      check("pin_m2_b2b_count", 32'(cnt_b), (k % 2 == 0) ? 0 : 1);
      check("pin_m2_b2b_wrap",  32'(wr_b),  1);
    end
    up_b = 1'b1;
    tick();
    check("pin_m2_up_wrap", 32'(wr_b), 1);
    tick();
    check("pin_m2_up_nowrap", 32'(wr_b), 0);
    en_b = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
